// File: rtl/axi_read_data_ctl.sv
// axi_read_data_ctl: AXI R-channel to NoC flit converter for one packet.
// Decodes data-flit count and packet address from the header beats, tags
// head/tail, and forwards each beat through a one-stage output register.
// Optional feature macro: NOU_RD_RESP_CHECK_EN (sticky rresp/rlast error flag).

`ifndef NOU_PKT_FLIT_WIDTH
`define NOU_PKT_FLIT_WIDTH 8
`endif

module axi_read_data_ctl #(
    parameter int DATA_W  = 128,
    parameter int CNT_W   = `NOU_PKT_FLIT_WIDTH,
    parameter int LEN_LSB = 0,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_rd,
    input  logic [CNT_W-1:0]  header_flit_num,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    output logic              flit_vld,
    input  logic              flit_rdy,
    output logic [DATA_W-1:0] flit_data,
    output logic              flit_head,
    output logic              flit_tail,
    output logic [CNT_W-1:0]  data_flit_num,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic              hdr_info_vld,
    output logic              busy,
    output logic              rd_done,
    output logic              rd_err
);

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        RECV_HDR  = 4'b0010,
        RECV_DATA = 4'b0100,
        DRAIN     = 4'b1000
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   hdr_num;
    logic [CNT_W-1:0]   hdr_num_eff;
    logic               start_acc;
    logic               beat_acc;
    logic               hdr_last;
    logic               data_last;
    logic               tail_beat;
    logic               tail_hs;

    // Output pipeline register (stage p1)
    logic               vld_p1;
    logic [DATA_W-1:0]  data_p1;
    logic               head_p1;
    logic               tail_p1;

    // A header count below 2 still carries count and address beats
    assign hdr_num_eff = (header_flit_num < CNT_W'(2)) ? CNT_W'(2) : header_flit_num;
    assign start_acc   = (state == IDLE) && start_rd;
    assign busy        = (state != IDLE);
    assign axi_rready  = ((state == RECV_HDR) || (state == RECV_DATA)) && (!vld_p1 || flit_rdy);
    assign beat_acc    = axi_rvalid && axi_rready;
    assign hdr_last    = (cnt == hdr_num - CNT_W'(1));
    assign data_last   = (cnt == data_flit_num - CNT_W'(1));
    assign tail_hs     = vld_p1 && flit_rdy && tail_p1;

    assign flit_vld  = vld_p1;
    assign flit_data = data_p1;
    assign flit_head = head_p1;
    assign flit_tail = tail_p1;

    // Next-state, counter and tail-beat decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tail_beat = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_rd) state_nxt = RECV_HDR;
            end
            RECV_HDR: begin
                if (beat_acc) begin
                    if (hdr_last) begin
                        cnt_nxt = '0;
                        if (data_flit_num == '0) begin
                            tail_beat = 1'b1;
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = RECV_DATA;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            RECV_DATA: begin
                if (beat_acc) begin
                    if (data_last) begin
                        cnt_nxt   = '0;
                        tail_beat = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (tail_hs) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and latched header count
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hdr_num <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start_acc) hdr_num <= hdr_num_eff;
        end
    end

    // Header field decode: count from beat 0, address from beat 1
    always_ff @(posedge clk) begin
        if (rst) begin
            data_flit_num <= '0;
            pkt_addr      <= '0;
            hdr_info_vld  <= 1'b0;
        end else begin
            hdr_info_vld <= beat_acc && (state == RECV_HDR) && (cnt == CNT_W'(1));
            if (beat_acc && (state == RECV_HDR)) begin
                if (cnt == '0) data_flit_num <= axi_rdata[LEN_LSB +: CNT_W];
                if (cnt == CNT_W'(1)) pkt_addr <= axi_rdata[ADDR_W-1:0];
            end
        end
    end

    // Stage p1: output flit register, holds while stalled downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            head_p1 <= 1'b0;
            tail_p1 <= 1'b0;
        end else if (beat_acc) begin
            vld_p1  <= 1'b1;
            data_p1 <= axi_rdata;
            head_p1 <= (state == RECV_HDR) && (cnt == '0);
            tail_p1 <= tail_beat;
        end else if (flit_rdy) begin
            vld_p1  <= 1'b0;
            head_p1 <= 1'b0;
            tail_p1 <= 1'b0;
        end
    end

    // Completion pulse one cycle after the tail flit is handed off
    always_ff @(posedge clk) begin
        if (rst) rd_done <= 1'b0;
        else     rd_done <= (state == DRAIN) && tail_hs;
    end

`ifdef NOU_RD_RESP_CHECK_EN
    // Sticky response-error flag, cleared when a new packet starts
    always_ff @(posedge clk) begin
        if (rst)
            rd_err <= 1'b0;
        else if (start_acc)
            rd_err <= 1'b0;
        else if (beat_acc && ((axi_rresp != 2'b00) || !axi_rlast))
            rd_err <= 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^{axi_rresp, axi_rlast};
    assign rd_err      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_read_data_ctl.sv
// Testbench for axi_read_data_ctl: directed packets with a flit scoreboard.
// Honors NOU_RD_RESP_CHECK_EN to select the expected rd_err behaviour.

module tb_axi_read_data_ctl;

    localparam int DATA_W = 128;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_rd;
    logic [CNT_W-1:0]  header_flit_num;
    logic              axi_rvalid;
    logic              axi_rready;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              flit_vld;
    logic              flit_rdy;
    logic [DATA_W-1:0] flit_data;
    logic              flit_head;
    logic              flit_tail;
    logic [CNT_W-1:0]  data_flit_num;
    logic [ADDR_W-1:0] pkt_addr;
    logic              hdr_info_vld;
    logic              busy;
    logic              rd_done;
    logic              rd_err;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              head;
        logic              tail;
    } flit_t;

    flit_t sb[$];
    flit_t mon_e;
    int    total = 0;
    int    passed = 0;
    int    hinfo_total = 0;
    logic  tail_hs_prev = 1'b0;

    axi_read_data_ctl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .LEN_LSB(0),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_rd       (start_rd),
        .header_flit_num(header_flit_num),
        .axi_rvalid     (axi_rvalid),
        .axi_rready     (axi_rready),
        .axi_rdata      (axi_rdata),
        .axi_rresp      (axi_rresp),
        .axi_rlast      (axi_rlast),
        .flit_vld       (flit_vld),
        .flit_rdy       (flit_rdy),
        .flit_data      (flit_data),
        .flit_head      (flit_head),
        .flit_tail      (flit_tail),
        .data_flit_num  (data_flit_num),
        .pkt_addr       (pkt_addr),
        .hdr_info_vld   (hdr_info_vld),
        .busy           (busy),
        .rd_done        (rd_done),
        .rd_err         (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: scoreboard pop, stall and rd_done timing checks
    always @(negedge clk) begin
        if (!rst) begin
            if (flit_vld && !flit_rdy) chk("rready_stall", axi_rready, 1'b0);
            if (rd_done || tail_hs_prev) chk("rd_done_timing", rd_done, tail_hs_prev);
            if (hdr_info_vld) hinfo_total <= hinfo_total + 1;
            if (flit_vld && flit_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_has_entry", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("flit_data", flit_data, mon_e.data);
                    chk("flit_head", flit_head, mon_e.head);
                    chk("flit_tail", flit_tail, mon_e.tail);
                end
            end
        end
        tail_hs_prev <= !rst && flit_vld && flit_rdy && flit_tail;
    end

    task automatic check_reset();
        chk("rst_flit_vld", flit_vld, 1'b0);
        chk("rst_flit_head", flit_head, 1'b0);
        chk("rst_flit_tail", flit_tail, 1'b0);
        chk("rst_flit_data", flit_data, '0);
        chk("rst_axi_rready", axi_rready, 1'b0);
        chk("rst_hdr_info_vld", hdr_info_vld, 1'b0);
        chk("rst_rd_done", rd_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_data_flit_num", data_flit_num, '0);
        chk("rst_pkt_addr", pkt_addr, '0);
    endtask

    // One packet: h_in header beats (clamped to 2), ndata data beats.
    // abort_at > 0 asserts rst once that many beats have been accepted.
    task automatic run_pkt(input int h_in, input int ndata, input logic [ADDR_W-1:0] addr,
                           input bit bp, input int err_beat, input int abort_at);
        int h, nb, i, cyc, hi0;
        logic [DATA_W-1:0] beats[$];
        logic [DATA_W-1:0] w;
        logic acc, got_done, err_exp;
        h  = (h_in < 2) ? 2 : h_in;
        nb = h + ndata;
        for (int k = 0; k < nb; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            if (k == 0) w[CNT_W-1:0] = CNT_W'(ndata);
            if (k == 1) w[ADDR_W-1:0] = addr;
            beats.push_back(w);
        end
`ifdef NOU_RD_RESP_CHECK_EN
        err_exp = (err_beat >= 0) && (err_beat < nb);
`else
        err_exp = 1'b0;
`endif
        hi0 = hinfo_total;
        @(posedge clk); #1;
        header_flit_num = CNT_W'(h_in);
        start_rd = 1'b1;
        @(posedge clk); #1;
        start_rd = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("rd_err_cleared_at_start", rd_err, 1'b0);
        i = 0;
        cyc = 0;
        while (i < nb && !(abort_at > 0 && i == abort_at) && cyc < 200) begin
            axi_rvalid = 1'b1;
            axi_rdata  = beats[i];
            axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            axi_rlast  = 1'b1;
            flit_rdy   = bp ? cyc[0] : 1'b1;
            @(negedge clk);
            acc = axi_rready;
            if (acc) sb.push_back('{data: beats[i], head: (i == 0), tail: (i == nb - 1)});
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        axi_rvalid = 1'b0;
        axi_rresp  = 2'b00;
        if (abort_at > 0) begin
            chk("beats_before_abort", i, abort_at);
            rst      = 1'b1;
            flit_rdy = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_reset();
            sb.delete();
            @(posedge clk); #1;
            rst      = 1'b0;
            flit_rdy = 1'b1;
            return;
        end
        chk("beats_accepted", i, nb);
        if (!bp) chk("throughput_cycles", cyc, nb);
        got_done = 1'b0;
        for (int c = 0; c < 50 && !got_done; c++) begin
            flit_rdy = bp ? cyc[0] : 1'b1;
            cyc++;
            @(negedge clk);
            if (rd_done) begin
                got_done = 1'b1;
                chk("busy_at_done", busy, 1'b0);
                chk("rd_err_at_done", rd_err, err_exp);
            end
            @(posedge clk); #1;
        end
        flit_rdy = 1'b1;
        chk("rd_done_seen", got_done, 1'b1);
        @(negedge clk);
        chk("rd_done_single_pulse", rd_done, 1'b0);
        chk("hdr_info_once", hinfo_total - hi0, 1);
        chk("data_flit_num", data_flit_num, CNT_W'(ndata));
        chk("pkt_addr", pkt_addr, addr);
        chk("sb_drained", sb.size(), 0);
    endtask

    // Directed sequence
    initial begin
        rst             = 1'b1;
        start_rd        = 1'b0;
        header_flit_num = '0;
        axi_rvalid      = 1'b0;
        axi_rdata       = '0;
        axi_rresp       = 2'b00;
        axi_rlast       = 1'b0;
        flit_rdy        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        run_pkt(2, 3, 32'h1000_0040, 1'b0, -1, 0);
        run_pkt(2, 0, 32'h2000_0080, 1'b0, -1, 0);
        run_pkt(3, 4, 32'h3000_00C0, 1'b1, -1, 0);
        run_pkt(1, 2, 32'h4000_0100, 1'b0, -1, 0);
        run_pkt(2, 3, 32'h5000_0140, 1'b0, -1, 3);
        run_pkt(2, 2, 32'h6000_0180, 1'b0, -1, 0);
        run_pkt(2, 3, 32'h7000_01C0, 1'b1, 2, 0);
        run_pkt(2, 1, 32'h8000_0200, 1'b0, -1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
